// File: rtl/mic_frame_packer_pkg.sv
// -----------------------------------------------------------------------------
// mic_pack_pkg
// Shared definitions for the microphone frame packer:
//   - packer FSM state encoding
//   - default header sync marker and header field bit offsets
//   - FIFO word layout (sop + eop + 64-bit data)
//   - words_per_frame(): header word plus one word per channel pair
// No ports (package).
// -----------------------------------------------------------------------------
package mic_pack_pkg;

    typedef enum logic [0:0] {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } pack_state_t;

    localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hA5A5;

    // Header layout: {sync[63:48], frame_cnt[47:32], num_channels[31:24], zero[23:0]}
    localparam int unsigned HDR_SYNC_LSB = 32'd48;
    localparam int unsigned HDR_CNT_LSB  = 32'd32;
    localparam int unsigned HDR_NCH_LSB  = 32'd24;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [63:0] data;
    } fifo_word_t;

    function automatic int unsigned words_per_frame(input int unsigned num_channels);
        return 32'd1 + (num_channels / 32'd2);
    endfunction

endpackage

// File: rtl/mic_frame_packer_fifo.sv
// -----------------------------------------------------------------------------
// mic_frame_fifo
// Show-ahead FIFO of fifo_word_t (64-bit data + sop + eop) with two write
// pointers: a tentative pointer advanced by every write, and a committed
// pointer that is the only one visible to the read side. A whole frame is
// written tentatively and published at once by commit, or discarded by
// rollback (tentative pointer rewound to the committed pointer).
// Ports:
//   clk, reset_n   clock, synchronous active-low reset
//   wr, wr_data    tentative write (at rewound position when rollback is set)
//   commit         publish everything written so far, including this cycle
//   rollback       discard uncommitted words
//   count_free     free entries relative to the committed pointer
//   rd_valid/rd_ready/rd_data  show-ahead read port (data 0 when empty)
// -----------------------------------------------------------------------------
module mic_frame_fifo
    import mic_pack_pkg::*;
#(
    parameter int unsigned DEPTH = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   wr,
    input  fifo_word_t             wr_data,
    input  logic                   commit,
    input  logic                   rollback,
    output logic [$clog2(DEPTH):0] count_free,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output fifo_word_t             rd_data
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    fifo_word_t    mem_r [DEPTH];
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] cm_ptr_r;
    logic [PW-1:0] wr_base_s;
    logic [PW-1:0] wr_next_s;

    // Write position: a rollback rewinds first so a restarted frame can be written in the same cycle.
    always_comb begin
        if (rollback) begin
            wr_base_s = cm_ptr_r;
        end else begin
            wr_base_s = wr_ptr_r;
        end
        if (wr) begin
            wr_next_s = wr_base_s + PW'(1);
        end else begin
            wr_next_s = wr_base_s;
        end
    end

    // Storage array; left unreset because only committed entries are ever exposed.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem_r[wr_base_s[AW-1:0]] <= wr_data;
        end
    end

    // Pointer updates; read and commit in the same cycle are independent.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            cm_ptr_r <= {PW{1'b0}};
        end else begin
            wr_ptr_r <= wr_next_s;
            if (commit) begin
                cm_ptr_r <= wr_next_s;
            end
            if (rd_valid && rd_ready) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
        end
    end

    // Read side and free-space report, both derived from the committed pointer only.
    always_comb begin
        rd_valid   = (cm_ptr_r != rd_ptr_r);
        count_free = PW'(DEPTH) - (cm_ptr_r - rd_ptr_r);
        if (rd_valid) begin
            rd_data = mem_r[rd_ptr_r[AW-1:0]];
        end else begin
            rd_data = {1'b0, 1'b0, 64'h0};
        end
    end

endmodule

// File: rtl/mic_frame_packer.sv
// -----------------------------------------------------------------------------
// mic_frame_packer
// Packs one complete channel scan (ch 0..NUM_CHANNELS-1) of the microphone
// sample stream into a 64-bit framed Avalon-ST stream: a header word
// {sync, frame_cnt, num_channels, 24'h0} followed by NUM_CHANNELS/2 words
// {odd sample, even sample}. Incomplete or out-of-order scans never reach the
// output; scans that do not fit in the FIFO are dropped whole.
// Optional build macro MIC_FRAME_PACKER_STATS_EN adds saturating 16-bit
// counters of overflow and sync-loss events.
// Ports:
//   clk, reset_n                       clock, synchronous active-low reset
//   mic_input_data/channel/error/valid sample stream in (no backpressure)
//   frame_output_data/valid/ready      packed word stream out
//   frame_output_startofpacket         high on header word
//   frame_output_endofpacket           high on last pair word
//   status_sync_lost                   pulse: scan aborted, channel out of order
//   status_overflow                    pulse: scan dropped, no FIFO space
//   status_sample_error                pulse: accepted sample had error != 0
//   status_overflow_count, status_resync_count (MIC_FRAME_PACKER_STATS_EN only)
// -----------------------------------------------------------------------------
module mic_frame_packer
    import mic_pack_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS = 16,
    parameter int unsigned FIFO_DEPTH   = 32,
    parameter logic [15:0] SYNC_WORD    = SYNC_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] mic_input_data,
    input  logic [5:0]  mic_input_channel,
    input  logic [1:0]  mic_input_error,
    input  logic        mic_input_valid,
    output logic [63:0] frame_output_data,
    output logic        frame_output_valid,
    input  logic        frame_output_ready,
    output logic        frame_output_startofpacket,
    output logic        frame_output_endofpacket,
    output logic        status_sync_lost,
    output logic        status_overflow,
    output logic        status_sample_error
`ifdef MIC_FRAME_PACKER_STATS_EN
   ,output logic [15:0] status_overflow_count,
    output logic [15:0] status_resync_count
`endif
);

    localparam int unsigned   WPF     = words_per_frame(NUM_CHANNELS);
    localparam int unsigned   PW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [PW-1:0] WPF_W   = PW'(WPF);
    localparam logic [5:0]    LAST_CH = 6'(NUM_CHANNELS - 1);
    localparam logic [7:0]    NCH_W   = 8'(NUM_CHANNELS);

    pack_state_t   state_r;
    logic [15:0]   frame_cnt_r;
    logic [5:0]    exp_ch_r;
    logic [31:0]   even_r;
    logic          sync_lost_r;
    logic          overflow_r;
    logic          sample_err_r;

    logic [31:0]   sample_s;
    logic [15:0]   frame_cnt_inc_s;
    logic [63:0]   header_s;
    logic          start_s;
    logic          space_ok_s;
    logic          in_order_s;
    logic          mismatch_s;
    logic          last_s;
    logic          accept_s;
    logic          fifo_wr_s;
    logic          fifo_commit_s;
    logic          fifo_rollback_s;
    fifo_word_t    fifo_wr_data_s;
    fifo_word_t    fifo_rd_data_s;
    logic          fifo_rd_valid_s;
    logic [PW-1:0] count_free_s;

    // Classify the incoming sample and derive the FIFO write/commit/rollback controls.
    always_comb begin
        start_s    = 1'b0;
        in_order_s = 1'b0;
        mismatch_s = 1'b0;
        if (mic_input_error != 2'b00) begin
            sample_s = 32'h0;
        end else begin
            sample_s = mic_input_data;
        end
        if (mic_input_valid) begin
            case (state_r)
                HUNT: begin
                    start_s = (mic_input_channel == 6'd0);
                end
                COLLECT: begin
                    in_order_s = (mic_input_channel == exp_ch_r);
                    mismatch_s = (mic_input_channel != exp_ch_r);
                    // A channel 0 that breaks a scan also begins the next one.
                    start_s    = (mic_input_channel != exp_ch_r) && (mic_input_channel == 6'd0);
                end
                default: begin
                    start_s = 1'b0;
                end
            endcase
        end else begin
            start_s = 1'b0;
        end
        frame_cnt_inc_s = frame_cnt_r + 16'd1;
        space_ok_s      = (count_free_s >= WPF_W);
        last_s          = in_order_s && (exp_ch_r == LAST_CH);
        accept_s        = (start_s && space_ok_s) || in_order_s;

        header_s = 64'h0;
        header_s[HDR_SYNC_LSB +: 16] = SYNC_WORD;
        header_s[HDR_CNT_LSB  +: 16] = frame_cnt_inc_s;
        header_s[HDR_NCH_LSB  +: 8]  = NCH_W;

        fifo_rollback_s = mismatch_s;
        fifo_commit_s   = last_s;
        fifo_wr_s       = (start_s && space_ok_s) || (in_order_s && exp_ch_r[0]);
        if (start_s) begin
            fifo_wr_data_s = '{sop: 1'b1, eop: 1'b0, data: header_s};
        end else begin
            fifo_wr_data_s = '{sop: 1'b0, eop: last_s, data: {sample_s, even_r}};
        end
    end

    // Packer FSM: scan tracking, frame counter, even-sample latch and status pulses.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= HUNT;
            frame_cnt_r  <= 16'h0;
            exp_ch_r     <= 6'd0;
            even_r       <= 32'h0;
            sync_lost_r  <= 1'b0;
            overflow_r   <= 1'b0;
            sample_err_r <= 1'b0;
        end else begin
            sync_lost_r  <= mismatch_s;
            overflow_r   <= start_s && !space_ok_s;
            sample_err_r <= accept_s && (mic_input_error != 2'b00);
            if (start_s) begin
                // Every scan start is counted, even a dropped one, so the host sees the gap.
                frame_cnt_r <= frame_cnt_inc_s;
                if (space_ok_s) begin
                    state_r  <= COLLECT;
                    exp_ch_r <= 6'd1;
                    even_r   <= sample_s;
                end else begin
                    state_r  <= HUNT;
                    exp_ch_r <= 6'd0;
                end
            end else if (mismatch_s) begin
                state_r  <= HUNT;
                exp_ch_r <= 6'd0;
            end else if (in_order_s) begin
                if (!exp_ch_r[0]) begin
                    even_r <= sample_s;
                end
                if (last_s) begin
                    state_r  <= HUNT;
                    exp_ch_r <= 6'd0;
                end else begin
                    exp_ch_r <= exp_ch_r + 6'd1;
                end
            end
        end
    end

    mic_frame_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr         (fifo_wr_s),
        .wr_data    (fifo_wr_data_s),
        .commit     (fifo_commit_s),
        .rollback   (fifo_rollback_s),
        .count_free (count_free_s),
        .rd_valid   (fifo_rd_valid_s),
        .rd_ready   (frame_output_ready),
        .rd_data    (fifo_rd_data_s)
    );

    assign frame_output_data          = fifo_rd_data_s.data;
    assign frame_output_valid         = fifo_rd_valid_s;
    assign frame_output_startofpacket = fifo_rd_data_s.sop;
    assign frame_output_endofpacket   = fifo_rd_data_s.eop;
    assign status_sync_lost           = sync_lost_r;
    assign status_overflow            = overflow_r;
    assign status_sample_error        = sample_err_r;

`ifdef MIC_FRAME_PACKER_STATS_EN
    logic [15:0] ovf_cnt_r;
    logic [15:0] resync_cnt_r;

    // Saturating event counters for overflow and sync-loss pulses.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ovf_cnt_r    <= 16'h0;
            resync_cnt_r <= 16'h0;
        end else begin
            if (overflow_r && (ovf_cnt_r != 16'hFFFF)) begin
                ovf_cnt_r <= ovf_cnt_r + 16'd1;
            end
            if (sync_lost_r && (resync_cnt_r != 16'hFFFF)) begin
                resync_cnt_r <= resync_cnt_r + 16'd1;
            end
        end
    end

    assign status_overflow_count = ovf_cnt_r;
    assign status_resync_count   = resync_cnt_r;
`endif

endmodule
